// File: rtl/gs232c_ras_spec_pkg.sv
// Shared definitions for the GS232C return-address stack.
// Holds the encodings of the ra_src output and the state type of the
// committed-stack initialisation FSM.
package gs232c_ras_spec_pkg;

    // Source of the predicted return address
    localparam logic [1:0] RAS_SRC_WB = 2'd0;  // committed stack
    localparam logic [1:0] RAS_SRC_BR = 2'd1;  // branch-level entry
    localparam logic [1:0] RAS_SRC_PR = 2'd2;  // predict-level entry

    // Committed-stack initialisation FSM
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ras_state_t;

endpackage

// File: rtl/gs232c_ras_spec_level.sv
// Speculative level of the return-address stack (predict or branch level).
// A small direct-mapped store indexed by the low bits of a full stack slot
// number; the upper slot bits are kept as a tag so that a lookup only hits
// when the entry was written for exactly that slot.
//
// Ports:
//   clock, reset   - clock, synchronous active-high reset (clears valids)
//   clear          - flush: clear every valid bit
//   wr_en          - write wr_pc into the entry for stack slot wr_slot
//   wr_slot        - full stack slot number (IDX_W bits) of the write
//   wr_pc          - return address to store
//   rd_slot        - full stack slot number to look up
//   hit            - entry valid and its tag matches rd_slot
//   rd_pc          - stored return address of the looked-up entry
//
// LVL_DEPTH must be a power of two, at least 2 and below 2**IDX_W.
module gs232c_ras_level #(
    parameter int PC_W      = 30,
    parameter int IDX_W     = 4,
    parameter int LVL_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_slot,
    input  logic [PC_W-1:0]  wr_pc,
    input  logic [IDX_W-1:0] rd_slot,
    output logic             hit,
    output logic [PC_W-1:0]  rd_pc
);

    localparam int LVL_IDX_W = $clog2(LVL_DEPTH);
    localparam int TAG_W     = IDX_W - LVL_IDX_W;

    logic [LVL_DEPTH-1:0] valid_r;
    logic [TAG_W-1:0]     tag_r [LVL_DEPTH];
    logic [PC_W-1:0]      pc_r  [LVL_DEPTH];

    logic [LVL_IDX_W-1:0] wr_idx_s;
    logic [TAG_W-1:0]     wr_tag_s;
    logic [LVL_IDX_W-1:0] rd_idx_s;
    logic [TAG_W-1:0]     rd_tag_s;

    assign wr_idx_s = wr_slot[LVL_IDX_W-1:0];
    assign wr_tag_s = wr_slot[IDX_W-1:LVL_IDX_W];
    assign rd_idx_s = rd_slot[LVL_IDX_W-1:0];
    assign rd_tag_s = rd_slot[IDX_W-1:LVL_IDX_W];

    // Valid bits: a flush takes priority over a write in the same cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_r <= {LVL_DEPTH{1'b0}};
        end else if (clear) begin
            valid_r <= {LVL_DEPTH{1'b0}};
        end else if (wr_en) begin
            valid_r[wr_idx_s] <= 1'b1;
        end
    end

    // Tag and address storage; contents only matter while the valid bit is set
    always_ff @(posedge clock) begin
        if (wr_en && !clear && !reset) begin
            tag_r[wr_idx_s] <= wr_tag_s;
            pc_r[wr_idx_s]  <= wr_pc;
        end
    end

    // Lookup
    always_comb begin
        hit   = valid_r[rd_idx_s] && (tag_r[rd_idx_s] == rd_tag_s);
        rd_pc = pc_r[rd_idx_s];
    end

endmodule

// File: rtl/gs232c_ras_spec.sv
// GS232C return-address stack with three pipeline levels.
// The predict and branch levels hold speculative calls in small tagged
// stores; the writeback level owns the full committed stack. Each level has
// its own pointer. A flush invalidates the younger levels, whose pointers are
// reloaded from the next older valid pointer in the following (bubble) cycle.
// After reset the committed stack is zeroed one entry per cycle.
//
// Ports:
//   clock, reset              - clock, synchronous active-high reset
//   pr_link/pr_jrra/pr_link_pc - predict-stage call/return and return address
//   br_cancel                 - branch mispredict flush (predict level)
//   br_link/br_jrra/br_link_pc - branch-resolve call/return and return address
//   wb_cancel                 - writeback flush (predict and branch levels)
//   wb_link/wb_jrra/wb_link_pc - committed call/return and return address
//   ra, ra_src                - predicted return address and its source
//   init_busy                 - committed stack clear in progress
//   wb_count                  - committed occupancy, saturating 0..DEPTH
module gs232c_ras_spec
    import gs232c_ras_spec_pkg::*;
#(
    parameter int PC_W     = 30,
    parameter int DEPTH    = 16,
    parameter int PR_DEPTH = 4,
    parameter int BR_DEPTH = 2,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pr_link,
    input  logic             pr_jrra,
    input  logic [PC_W-1:0]  pr_link_pc,
    input  logic             br_cancel,
    input  logic             br_link,
    input  logic             br_jrra,
    input  logic [PC_W-1:0]  br_link_pc,
    input  logic             wb_cancel,
    input  logic             wb_link,
    input  logic             wb_jrra,
    input  logic [PC_W-1:0]  wb_link_pc,
    output logic [PC_W-1:0]  ra,
    output logic [1:0]       ra_src,
    output logic             init_busy,
    output logic [IDX_W:0]   wb_count
);

    localparam int              CW       = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_K  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W:0]   FULL_CNT = CW'(DEPTH);

    // Link only: +1, return only: -1, both (return-then-call) or neither: hold
    function automatic logic [IDX_W-1:0] ptr_step(input logic [IDX_W-1:0] ptr,
                                                  input logic link,
                                                  input logic jrra);
        logic [IDX_W-1:0] nxt;
        case ({link, jrra})
            2'b10:   nxt = ptr + IDX_W'(1);
            2'b01:   nxt = ptr - IDX_W'(1);
            default: nxt = ptr;
        endcase
        return nxt;
    endfunction

    // A call that is also a return overwrites the top entry instead of pushing
    function automatic logic [IDX_W-1:0] link_slot(input logic [IDX_W-1:0] ptr,
                                                   input logic jrra);
        return jrra ? ptr : ptr + IDX_W'(1);
    endfunction

    ras_state_t       state_r, state_s;
    logic [IDX_W-1:0] init_k_r, init_k_s;
    logic [IDX_W-1:0] pr_ptr_r, pr_ptr_s;
    logic [IDX_W-1:0] br_ptr_r, br_ptr_s;
    logic [IDX_W-1:0] wb_ptr_r, wb_ptr_s;
    logic             pr_vld_r, pr_vld_s;
    logic             br_vld_r, br_vld_s;
    logic [IDX_W:0]   wb_count_r, wb_count_s;
    logic [PC_W-1:0]  committed_r [DEPTH];

    logic             run_s;
    logic             pr_flush_s, br_flush_s;
    logic             pr_wr_s, br_wr_s;
    logic [IDX_W-1:0] pr_slot_s, br_slot_s, wb_slot_s;
    logic             pr_hit_s, br_hit_s;
    logic [PC_W-1:0]  pr_pc_s, br_pc_s;

    // Qualified controls: every input is ignored while the stack initialises,
    // and a level's own inputs are ignored while it is flushed or reloading
    always_comb begin
        run_s      = (state_r == ST_RUN);
        pr_flush_s = run_s && (br_cancel || wb_cancel);
        br_flush_s = run_s && wb_cancel;
        pr_wr_s    = run_s && pr_vld_r && !br_cancel && !wb_cancel && pr_link;
        br_wr_s    = run_s && br_vld_r && !wb_cancel && br_link;
        pr_slot_s  = link_slot(pr_ptr_r, pr_jrra);
        br_slot_s  = link_slot(br_ptr_r, br_jrra);
        wb_slot_s  = link_slot(wb_ptr_r, wb_jrra);
    end

    // Init FSM next state: walk k over every committed entry, then run
    always_comb begin
        state_s  = state_r;
        init_k_s = init_k_r;
        case (state_r)
            ST_INIT: begin
                init_k_s = init_k_r + IDX_W'(1);
                if (init_k_r == LAST_K) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_RUN:  state_s = ST_RUN;
            default: state_s = ST_INIT;
        endcase
    end

    // Pointer next state; an invalid pointer reloads from the next older
    // level (its registered value) regardless of the FSM state
    always_comb begin
        pr_ptr_s = pr_ptr_r;
        pr_vld_s = pr_vld_r;
        if (pr_flush_s) begin
            pr_vld_s = 1'b0;
        end else if (!pr_vld_r) begin
            pr_ptr_s = br_vld_r ? br_ptr_r : wb_ptr_r;
            pr_vld_s = 1'b1;
        end else if (run_s) begin
            pr_ptr_s = ptr_step(pr_ptr_r, pr_link, pr_jrra);
        end else begin
            pr_ptr_s = pr_ptr_r;
        end

        br_ptr_s = br_ptr_r;
        br_vld_s = br_vld_r;
        if (br_flush_s) begin
            br_vld_s = 1'b0;
        end else if (!br_vld_r) begin
            br_ptr_s = wb_ptr_r;
            br_vld_s = 1'b1;
        end else if (run_s) begin
            br_ptr_s = ptr_step(br_ptr_r, br_link, br_jrra);
        end else begin
            br_ptr_s = br_ptr_r;
        end

        if (run_s) begin
            wb_ptr_s = ptr_step(wb_ptr_r, wb_link, wb_jrra);
        end else begin
            wb_ptr_s = wb_ptr_r;
        end
    end

    // Committed occupancy, saturating at both ends
    always_comb begin
        wb_count_s = wb_count_r;
        if (run_s && wb_link && !wb_jrra) begin
            if (wb_count_r != FULL_CNT) begin
                wb_count_s = wb_count_r + CW'(1);
            end else begin
                wb_count_s = wb_count_r;
            end
        end else if (run_s && wb_jrra && !wb_link) begin
            if (wb_count_r != CW'(0)) begin
                wb_count_s = wb_count_r - CW'(1);
            end else begin
                wb_count_s = wb_count_r;
            end
        end else begin
            wb_count_s = wb_count_r;
        end
    end

    // Control state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_INIT;
            init_k_r   <= {IDX_W{1'b0}};
            pr_ptr_r   <= {IDX_W{1'b0}};
            br_ptr_r   <= {IDX_W{1'b0}};
            wb_ptr_r   <= {IDX_W{1'b0}};
            pr_vld_r   <= 1'b0;
            br_vld_r   <= 1'b0;
            wb_count_r <= {CW{1'b0}};
        end else begin
            state_r    <= state_s;
            init_k_r   <= init_k_s;
            pr_ptr_r   <= pr_ptr_s;
            br_ptr_r   <= br_ptr_s;
            wb_ptr_r   <= wb_ptr_s;
            pr_vld_r   <= pr_vld_s;
            br_vld_r   <= br_vld_s;
            wb_count_r <= wb_count_s;
        end
    end

    // Committed stack: zero-fill during init, committed calls afterwards;
    // overflow wraps and silently overwrites the oldest entry
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_r == ST_INIT) begin
                committed_r[init_k_r] <= {PC_W{1'b0}};
            end else if (wb_link) begin
                committed_r[wb_slot_s] <= wb_link_pc;
            end
        end
    end

    // Both speculative levels are looked up with the predict pointer
    gs232c_ras_level #(
        .PC_W      (PC_W),
        .IDX_W     (IDX_W),
        .LVL_DEPTH (PR_DEPTH)
    ) u_pr_level (
        .clock   (clock),
        .reset   (reset),
        .clear   (pr_flush_s),
        .wr_en   (pr_wr_s),
        .wr_slot (pr_slot_s),
        .wr_pc   (pr_link_pc),
        .rd_slot (pr_ptr_r),
        .hit     (pr_hit_s),
        .rd_pc   (pr_pc_s)
    );

    gs232c_ras_level #(
        .PC_W      (PC_W),
        .IDX_W     (IDX_W),
        .LVL_DEPTH (BR_DEPTH)
    ) u_br_level (
        .clock   (clock),
        .reset   (reset),
        .clear   (br_flush_s),
        .wr_en   (br_wr_s),
        .wr_slot (br_slot_s),
        .wr_pc   (br_link_pc),
        .rd_slot (pr_ptr_r),
        .hit     (br_hit_s),
        .rd_pc   (br_pc_s)
    );

    // Return-address select; forced to zero while the committed stack is
    // still being cleared so no stale entry is ever presented
    always_comb begin
        if (!run_s) begin
            ra     = {PC_W{1'b0}};
            ra_src = RAS_SRC_WB;
        end else if (pr_hit_s) begin
            ra     = pr_pc_s;
            ra_src = RAS_SRC_PR;
        end else if (br_hit_s) begin
            ra     = br_pc_s;
            ra_src = RAS_SRC_BR;
        end else begin
            ra     = committed_r[pr_ptr_r];
            ra_src = RAS_SRC_WB;
        end
    end

    assign init_busy = (state_r == ST_INIT);
    assign wb_count  = wb_count_r;

endmodule

// File: tb/tb_gs232c_ras_spec.sv
// Self-checking bench for gs232c_ras_spec: directed scenarios plus a
// randomized run checked against a behavioural model that keeps each level
// as a stack of (slot, address) pairs addressed by plain modular arithmetic.
module tb_gs232c_ras_spec;

    localparam int PC_W = 30;
    localparam int D    = 16;
    localparam int PRD  = 4;
    localparam int BRD  = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            pr_link = 1'b0, pr_jrra = 1'b0;
    logic [PC_W-1:0] pr_link_pc = '0;
    logic            br_cancel = 1'b0;
    logic            br_link = 1'b0, br_jrra = 1'b0;
    logic [PC_W-1:0] br_link_pc = '0;
    logic            wb_cancel = 1'b0;
    logic            wb_link = 1'b0, wb_jrra = 1'b0;
    logic [PC_W-1:0] wb_link_pc = '0;
    logic [PC_W-1:0] ra;
    logic [1:0]      ra_src;
    logic            init_busy;
    logic [4:0]      wb_count;

    int checks = 0;
    int errors = 0;

    gs232c_ras_spec #(.PC_W(PC_W), .DEPTH(D), .PR_DEPTH(PRD), .BR_DEPTH(BRD)) dut (
        .clock(clock), .reset(reset),
        .pr_link(pr_link), .pr_jrra(pr_jrra), .pr_link_pc(pr_link_pc),
        .br_cancel(br_cancel),
        .br_link(br_link), .br_jrra(br_jrra), .br_link_pc(br_link_pc),
        .wb_cancel(wb_cancel),
        .wb_link(wb_link), .wb_jrra(wb_jrra), .wb_link_pc(wb_link_pc),
        .ra(ra), .ra_src(ra_src), .init_busy(init_busy), .wb_count(wb_count)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    bit              m_run;
    int              m_k;
    logic [PC_W-1:0] m_comm [D];
    int              m_pr_ptr, m_br_ptr, m_wb_ptr, m_cnt;
    bit              m_pr_ok, m_br_ok;
    bit              m_prv [PRD];
    int              m_pra [PRD];
    logic [PC_W-1:0] m_prpc [PRD];
    bit              m_brv [BRD];
    int              m_bra [BRD];
    logic [PC_W-1:0] m_brpc [BRD];

    task automatic model_step();
        int p_old, b_old, w_old, slot;
        bit pok_old, bok_old, run;
        if (reset) begin
            m_run = 0; m_k = 0; m_cnt = 0;
            m_pr_ptr = 0; m_br_ptr = 0; m_wb_ptr = 0;
            m_pr_ok = 0; m_br_ok = 0;
            for (int i = 0; i < PRD; i++) m_prv[i] = 0;
            for (int i = 0; i < BRD; i++) m_brv[i] = 0;
            return;
        end
        p_old = m_pr_ptr; b_old = m_br_ptr; w_old = m_wb_ptr;
        pok_old = m_pr_ok; bok_old = m_br_ok; run = m_run;
        // predict level
        if (run && (br_cancel || wb_cancel)) begin
            for (int i = 0; i < PRD; i++) m_prv[i] = 0;
            m_pr_ok = 0;
        end else if (!pok_old) begin
            m_pr_ptr = bok_old ? b_old : w_old;
            m_pr_ok = 1;
        end else if (run) begin
            if (pr_link) begin
                slot = pr_jrra ? p_old : (p_old + 1) % D;
                m_prv[slot % PRD] = 1; m_pra[slot % PRD] = slot; m_prpc[slot % PRD] = pr_link_pc;
            end
            if (pr_link && !pr_jrra) m_pr_ptr = (p_old + 1) % D;
            if (pr_jrra && !pr_link) m_pr_ptr = (p_old + D - 1) % D;
        end
        // branch level
        if (run && wb_cancel) begin
            for (int i = 0; i < BRD; i++) m_brv[i] = 0;
            m_br_ok = 0;
        end else if (!bok_old) begin
            m_br_ptr = w_old;
            m_br_ok = 1;
        end else if (run) begin
            if (br_link) begin
                slot = br_jrra ? b_old : (b_old + 1) % D;
                m_brv[slot % BRD] = 1; m_bra[slot % BRD] = slot; m_brpc[slot % BRD] = br_link_pc;
            end
            if (br_link && !br_jrra) m_br_ptr = (b_old + 1) % D;
            if (br_jrra && !br_link) m_br_ptr = (b_old + D - 1) % D;
        end
        // committed level
        if (run) begin
            if (wb_link) m_comm[wb_jrra ? w_old : (w_old + 1) % D] = wb_link_pc;
            if (wb_link && !wb_jrra) begin
                m_wb_ptr = (w_old + 1) % D;
                if (m_cnt < D) m_cnt++;
            end
            if (wb_jrra && !wb_link) begin
                m_wb_ptr = (w_old + D - 1) % D;
                if (m_cnt > 0) m_cnt--;
            end
        end else begin
            m_comm[m_k] = '0;
            m_k++;
            if (m_k == D) begin m_k = 0; m_run = 1; end
        end
    endtask

    function automatic logic [PC_W-1:0] exp_ra();
        int p = m_pr_ptr;
        if (!m_run) return '0;
        if (m_prv[p % PRD] && m_pra[p % PRD] == p) return m_prpc[p % PRD];
        if (m_brv[p % BRD] && m_bra[p % BRD] == p) return m_brpc[p % BRD];
        return m_comm[p];
    endfunction

    function automatic logic [1:0] exp_src();
        int p = m_pr_ptr;
        if (!m_run) return 2'd0;
        if (m_prv[p % PRD] && m_pra[p % PRD] == p) return 2'd2;
        if (m_brv[p % BRD] && m_bra[p % BRD] == p) return 2'd1;
        return 2'd0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_in();
        pr_link = 0; pr_jrra = 0; pr_link_pc = '0;
        br_cancel = 0; br_link = 0; br_jrra = 0; br_link_pc = '0;
        wb_cancel = 0; wb_link = 0; wb_jrra = 0; wb_link_pc = '0;
    endtask

    // One clock: inputs set at the previous falling edge are sampled at the
    // rising edge, the model advances, and outputs are observed at the next
    // falling edge.
    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        clear_in();
    endtask

    task automatic do_reset();
        reset = 1; repeat (3) tick();
        reset = 0; repeat (D) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int busy_n;
        reset = 1; repeat (20) tick();
        checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", init_busy); end
        checks++; if (ra !== '0 || ra_src !== 2'd0) begin errors++; $display("FAIL reset_ra got %h/%0d want 0/0", ra, ra_src); end
        checks++; if (wb_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", wb_count); end
        for (int pass = 0; pass < 2; pass++) begin
            reset = 0;
            busy_n = 0;
            for (int i = 0; i < 40; i++) begin
                if (init_busy !== 1'b1) break;
                busy_n++;
                tick();
            end
            checks++; if (busy_n != D) begin errors++; $display("FAIL init_len pass %0d got %0d want %0d", pass, busy_n, D); end
            checks++; if (ra !== '0 || ra_src !== 2'd0) begin errors++; $display("FAIL post_init_ra got %h/%0d want 0/0", ra, ra_src); end
            if (pass == 0) begin
                // restart in the middle of the next init sequence
                reset = 1; tick(); reset = 0; repeat (5) tick();
                reset = 1; repeat (2) tick();
            end
        end
    endtask

    task automatic test_pr_stack();
        do_reset();
        pr_link = 1; pr_link_pc = 30'h100; tick();
        pr_link = 1; pr_link_pc = 30'h200; tick();
        checks++; if (ra !== 30'h200 || ra_src !== 2'd2) begin errors++; $display("FAIL pr_push got %h/%0d want 200/2", ra, ra_src); end
        pr_jrra = 1; tick();
        checks++; if (ra !== 30'h100 || ra_src !== 2'd2) begin errors++; $display("FAIL pr_pop got %h/%0d want 100/2", ra, ra_src); end
    endtask

    task automatic test_cancels();
        do_reset();
        wb_link = 1; wb_link_pc = 30'h100;
        br_link = 1; br_link_pc = 30'h100;
        pr_link = 1; pr_link_pc = 30'h100; tick();
        br_link = 1; br_link_pc = 30'h200;
        pr_link = 1; pr_link_pc = 30'h200; tick();
        pr_link = 1; pr_link_pc = 30'h300; tick();
        checks++; if (ra !== 30'h300 || ra_src !== 2'd2) begin errors++; $display("FAIL pre_cancel got %h/%0d want 300/2", ra, ra_src); end
        br_cancel = 1; tick();
        tick();
        checks++; if (ra !== 30'h200 || ra_src !== 2'd1) begin errors++; $display("FAIL br_cancel got %h/%0d want 200/1", ra, ra_src); end
        checks++; if (dut.pr_ptr_r !== 4'd2) begin errors++; $display("FAIL br_cancel_ptr got %0d want 2", dut.pr_ptr_r); end
        wb_cancel = 1; br_cancel = 1; tick();
        tick();
        checks++; if (ra !== 30'h100 || ra_src !== 2'd0) begin errors++; $display("FAIL wb_cancel got %h/%0d want 100/0", ra, ra_src); end
        checks++;
        if (dut.pr_ptr_r !== 4'd1 || dut.br_ptr_r !== 4'd1 || dut.wb_ptr_r !== 4'd1) begin
            errors++;
            $display("FAIL wb_cancel_ptrs got %0d/%0d/%0d want 1/1/1", dut.pr_ptr_r, dut.br_ptr_r, dut.wb_ptr_r);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            wb_link = 1; wb_link_pc = PC_W'(i); tick();
        end
        checks++; if (wb_count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d want 16", wb_count); end
        wb_cancel = 1; tick();
        tick();
        checks++; if (ra !== 30'h11 || ra_src !== 2'd0) begin errors++; $display("FAIL ovf_wrap got %h/%0d want 11/0", ra, ra_src); end
        for (int i = 0; i < 20; i++) begin
            wb_jrra = 1; tick();
        end
        checks++; if (wb_count !== 5'd0) begin errors++; $display("FAIL underflow_count got %0d want 0", wb_count); end
        checks++; if ($isunknown(ra) || $isunknown(ra_src)) begin errors++; $display("FAIL underflow_x got %h/%b want known", ra, ra_src); end
    endtask

    task automatic test_ret_call();
        do_reset();
        pr_link = 1; pr_link_pc = 30'h0a0; tick();
        pr_link = 1; pr_link_pc = 30'h0b0; tick();
        pr_link = 1; pr_jrra = 1; pr_link_pc = 30'h400; tick();
        checks++; if (dut.pr_ptr_r !== 4'd2) begin errors++; $display("FAIL ret_call_ptr got %0d want 2", dut.pr_ptr_r); end
        checks++; if (ra !== 30'h400 || ra_src !== 2'd2) begin errors++; $display("FAIL ret_call_ra got %h/%0d want 400/2", ra, ra_src); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            pr_link = 1'($urandom_range(0, 1)); pr_jrra = 1'($urandom_range(0, 1));
            pr_link_pc = PC_W'($urandom);
            br_link = 1'($urandom_range(0, 1)); br_jrra = 1'($urandom_range(0, 1));
            br_link_pc = PC_W'($urandom);
            wb_link = 1'($urandom_range(0, 1)); wb_jrra = 1'($urandom_range(0, 2) == 0);
            wb_link_pc = PC_W'($urandom);
            br_cancel = ($urandom_range(0, 9) == 0);
            wb_cancel = ($urandom_range(0, 19) == 0);
            tick();
            checks++;
            if (ra !== exp_ra() || ra_src !== exp_src()) begin
                errors++;
                $display("FAIL rand_ra cycle %0d got %h/%0d want %h/%0d", c, ra, ra_src, exp_ra(), exp_src());
            end
            checks++;
            if (wb_count !== 5'(m_cnt) || init_busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_count cycle %0d got %0d/%b want %0d/0", c, wb_count, init_busy, m_cnt);
            end
        end
    endtask

    initial begin
        clear_in();
        @(negedge clock);
        test_reset();
        test_pr_stack();
        test_cancels();
        test_overflow();
        test_ret_call();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
